axil_manager_engine: RTL

Command-driven AXI4-Lite manager. It replaces hand-toggled per-channel enables with a queued transaction engine: write/read commands are buffered in a FIFO and executed strictly in order, one at a time. Each write drives AW+W and collects B. Each read drives AR and collects R. Every completed transaction returns one response beat on a valid/ready response port. It sits between a CPU/TB command source and the axi4 bus, parametrised in address/data width and queue depth.

---
 rtl/axil_manager_engine.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/axil_manager_engine.sv
// rtl/axil_manager_engine.sv - queued AXI4-Lite manager executing write/read commands strictly in order
// Optional watchdog: define AXIL_TIMEOUT_EN to add timeout_err / timeout_sticky.
module axil_manager_engine #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int CMD_DEPTH      = 4,
   parameter int TIMEOUT_CYCLES = 256,
   localparam int STRB_W        = DATA_W / 8
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic [STRB_W-1:0] cmd_strb,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_data,
   output logic [1:0]        rsp_resp,
   output logic              busy,
   output logic [ADDR_W-1:0] AWADDR,
   output logic              AWVALID,
   input  logic              AWREADY,
   output logic [DATA_W-1:0] WDATA,
   output logic [STRB_W-1:0] WSTRB,
   output logic              WVALID,
   input  logic              WREADY,
   input  logic [1:0]        BRESP,
   input  logic              BVALID,
   output logic              BREADY,
   output logic [ADDR_W-1:0] ARADDR,
   output logic              ARVALID,
   input  logic              ARREADY,
   input  logic [DATA_W-1:0] RDATA,
   input  logic [1:0]        RRESP,
   input  logic              RVALID,
   output logic              RREADY
`ifdef AXIL_TIMEOUT_EN
   ,
   output logic              timeout_err,
   output logic              timeout_sticky
`endif
);

   localparam int PTR_W   = $clog2(CMD_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = 1 + ADDR_W + DATA_W + STRB_W;

   typedef enum logic [2:0] {
      ST_IDLE, ST_WR, ST_WR_B, ST_RD_A, ST_RD_R, ST_RSP
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [ENTRY_W-1:0]  r_fifo [CMD_DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]    r_count, w_count_nxt;
   logic                r_cmd_ready;
   logic                w_push, w_pop, w_empty;
   logic [ENTRY_W-1:0]  w_head;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_data;
   logic [STRB_W-1:0]   r_strb;
   logic                r_aw_done, r_w_done;
   logic                r_rsp_write;
   logic [DATA_W-1:0]   r_rsp_data;
   logic [1:0]          r_rsp_resp;

   assign w_empty = (r_count == '0);
   assign w_push  = cmd_valid && r_cmd_ready;
   assign w_pop   = (r_state == ST_IDLE) && !w_empty;
   assign w_head  = r_fifo[r_rd_ptr];

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop)
         w_count_nxt = r_count + CNT_W'(1);
      else if (!w_push && w_pop)
         w_count_nxt = r_count - CNT_W'(1);
   end

   // cmd_ready is registered from the next count so pop never reaches it combinationally
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_cmd_ready <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count     <= w_count_nxt;
         r_cmd_ready <= (w_count_nxt != CNT_W'(CMD_DEPTH));
      end
   end

   always_ff @(posedge ACLK) begin
      if (w_push)
         r_fifo[r_wr_ptr] <= {cmd_write, cmd_addr, cmd_data, cmd_strb};
   end

   always_comb begin
      w_state_nxt = r_state;
      AWVALID     = 1'b0;
      WVALID      = 1'b0;
      BREADY      = 1'b0;
      ARVALID     = 1'b0;
      RREADY      = 1'b0;
      rsp_valid   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty)
               w_state_nxt = w_head[ENTRY_W-1] ? ST_WR : ST_RD_A;
         end
         ST_WR: begin
            AWVALID = !r_aw_done;
            WVALID  = !r_w_done;
            if ((r_aw_done || AWREADY) && (r_w_done || WREADY))
               w_state_nxt = ST_WR_B;
         end
         ST_WR_B: begin
            BREADY = 1'b1;
            if (BVALID)
               w_state_nxt = ST_RSP;
         end
         ST_RD_A: begin
            ARVALID = 1'b1;
            if (ARREADY)
               w_state_nxt = ST_RD_R;
         end
         ST_RD_R: begin
            RREADY = 1'b1;
            if (RVALID)
               w_state_nxt = ST_RSP;
         end
         ST_RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_data      <= '0;
         r_strb      <= '0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_rsp_write <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_resp  <= 2'b00;
      end else begin
         r_state <= w_state_nxt;
         if (w_pop) begin
            r_addr    <= w_head[ENTRY_W-2 -: ADDR_W];
            r_data    <= w_head[STRB_W +: DATA_W];
            r_strb    <= w_head[STRB_W-1:0];
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end
         if (r_state == ST_WR) begin
            if (AWVALID && AWREADY)
               r_aw_done <= 1'b1;
            if (WVALID && WREADY)
               r_w_done <= 1'b1;
         end
         if (r_state == ST_WR_B && BVALID) begin
            r_rsp_write <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_resp  <= BRESP;
         end
         if (r_state == ST_RD_R && RVALID) begin
            r_rsp_write <= 1'b0;
            r_rsp_data  <= RDATA;
            r_rsp_resp  <= RRESP;
         end
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign rsp_write = r_rsp_write;
   assign rsp_data  = r_rsp_data;
   assign rsp_resp  = r_rsp_resp;
   assign busy      = (r_state != ST_IDLE) || !w_empty;
   assign AWADDR    = r_addr;
   assign ARADDR    = r_addr;
   assign WDATA     = r_data;
   assign WSTRB     = r_strb;

`ifdef AXIL_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] r_tmo_cnt;
   logic             r_timeout_err, r_timeout_sticky;
   logic             w_waiting, w_tmo_hit;

   assign w_waiting = (r_state == ST_WR) || (r_state == ST_WR_B) ||
                      (r_state == ST_RD_A) || (r_state == ST_RD_R);
   // Counter saturates at the limit so a long stall reports exactly once
   assign w_tmo_hit = w_waiting && (w_state_nxt == r_state) &&
                      (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_tmo_cnt        <= '0;
         r_timeout_err    <= 1'b0;
         r_timeout_sticky <= 1'b0;
      end else begin
         if (w_state_nxt != r_state)
            r_tmo_cnt <= '0;
         else if (w_waiting && r_tmo_cnt != TMO_W'(TIMEOUT_CYCLES))
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
         r_timeout_err <= w_tmo_hit;
         if (w_tmo_hit)
            r_timeout_sticky <= 1'b1;
      end
   end

   assign timeout_err    = r_timeout_err;
   assign timeout_sticky = r_timeout_sticky;
`else
`endif

endmodule
